if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port freeze, input, 1, hazard stall from decode; holds PC and IF/ID outputs.
REQ-005 The block SHALL have port branch_taken, input, 1, redirect request from execute.
REQ-006 The block SHALL have port branch_addr, input, 32, redirect target.
REQ-007 The block SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-008 The block SHALL have port imem_addr, output, 32, fetch address, always equal to the PC register.
REQ-009 The block SHALL have port imem_rdata, input, 32, fetched word, valid only when imem_ready=1.
REQ-010 The block SHALL have port imem_ready, input, 1, fetch completion strobe; may be delayed any number of cycles.
REQ-011 The block SHALL have port pc_out, output, 32, registered PC+4 of the instruction in IF/ID.
REQ-012 The block SHALL have port instruction, output, 32, registered instruction driving decode.
REQ-013 The block SHALL have port valid, output, 1, instruction/pc_out hold a real instruction (0 = bubble).

Function
REQ-014 The block SHALL implement FSM states REQ and HOLD.
- REQ: imem_req=1.
- HOLD: imem_req=0; a fetched word is parked in a 32-bit hold buffer with its PC+4.
REQ-015 In REQ, when imem_ready=1, freeze=0 and branch_taken=0, the block SHALL, at the same edge:
- load instruction<=imem_rdata, pc_out<=PC+4, valid<=1;
- set PC<=PC+4;
- remain in REQ.
REQ-016 In REQ, when imem_ready=1, freeze=1 and branch_taken=0, the block SHALL:
- store imem_rdata and PC+4 in the hold buffer;
- keep PC, instruction, pc_out and valid unchanged;
- go to HOLD.
REQ-017 In REQ, when imem_ready=0, branch_taken=0 and freeze=0, the block SHALL load valid<=0 and instruction<=0 (bubble), with PC and pc_out unchanged.
REQ-018 When freeze=1 and branch_taken=0, the block SHALL keep instruction, pc_out and valid unchanged in every state.
REQ-019 In HOLD, when freeze=0 and branch_taken=0, the block SHALL:
- load IF/ID from the hold buffer with valid<=1;
- set PC<=PC+4;
- go to REQ.
- One instruction per cycle is transferred; no fetch is issued in that cycle.
REQ-020 branch_taken=1 SHALL override freeze, imem_ready and state at the same edge:
- PC<={branch_addr[31:2],2'b00};
- valid<=0, instruction<=0, pc_out<=0;
- the hold buffer is discarded;
- go to REQ.
REQ-021 A word returned with imem_ready=1 in the same cycle as branch_taken=1 SHALL be discarded.
REQ-022 imem_addr SHALL change only at an edge.
- While imem_req=1 and imem_ready=0, imem_addr SHALL stay stable unless branch_taken=1.
REQ-023 PC+4 SHALL be computed modulo 2^32; PC=32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-024 PC bits [1:0] SHALL always be 0.
REQ-025 imem_req, imem_addr and valid SHALL depend only on registered state, never combinationally on imem_ready or freeze.

Reset
REQ-026 When rst=0 the block SHALL asynchronously set:
- PC=RESET_PC;
- state=REQ;
- instruction=0, pc_out=0, valid=0;
- hold buffer=0.
REQ-027 Reset asserted mid-fetch or in HOLD SHALL abandon the pending word.
- After release, the first request SHALL be at RESET_PC, with imem_req=1 in the first cycle after release.

Verification
REQ-028 The bench SHALL cover: reset release, imem_ready=1 every cycle, words A0..A3 -> imem_addr 0,4,8,C on consecutive cycles; valid=1 from the first edge after the first ready; pc_out=4,8,C,10.
REQ-029 The bench SHALL cover: imem_ready low for 3 cycles at PC=8 -> imem_addr holds 8; valid=0 and instruction=0 for 3 cycles; word at 8 then appears with pc_out=C.
REQ-030 The bench SHALL cover: freeze=1 at the edge the word at PC=4 returns -> state HOLD, imem_req=0, outputs frozen; freeze=0 two cycles later -> instruction=word@4, pc_out=8, next request at 8.
REQ-031 The bench SHALL cover: branch_taken=1, branch_addr=32'h0000_0103, with freeze=1 and imem_ready=1 -> returned word dropped, valid=0, next imem_addr=32'h0000_0100.
REQ-032 The bench SHALL cover: PC=32'hFFFF_FFFC with ready -> pc_out=0 and next imem_addr=0.
REQ-033 The bench SHALL cover: rst=0 pulsed asynchronously in HOLD -> outputs zero without a clock edge; first fetch after release at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch request FSM and IF/ID register.
// A word that returns during a decode freeze is parked until the freeze lifts.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = S_REQ;
        end else begin
            unique case (state_q)
                S_REQ:  if (imem_ready && freeze) state_d = S_HOLD;
                S_HOLD: if (!freeze) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req = (state_q == S_REQ);
    end

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (branch_taken) begin
            // Redirect wins over everything; any in-flight or parked word is dropped.
            pc_d         = branch_addr & 32'hFFFF_FFFC;
            instr_d      = 32'd0;
            pc_out_d     = 32'd0;
            valid_d      = 1'b0;
            hold_instr_d = 32'd0;
            hold_pc_d    = 32'd0;
        end else if (state_q == S_HOLD) begin
            if (!freeze) begin
                instr_d  = hold_instr_q;
                pc_out_d = hold_pc_q;
                valid_d  = 1'b1;
                pc_d     = pc_plus4;
            end
        end else if (imem_ready) begin
            if (freeze) begin
                hold_instr_d = imem_rdata;
                hold_pc_d    = pc_plus4;
            end else begin
                instr_d  = imem_rdata;
                pc_out_d = pc_plus4;
                valid_d  = 1'b1;
                pc_d     = pc_plus4;
            end
        end else if (!freeze) begin
            instr_d = 32'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= PC_INIT;
            instr_q      <= 32'd0;
            pc_out_q     <= 32'd0;
            valid_q      <= 1'b0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_out_q;
    assign instruction = instr_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random freeze/ready/branch traffic,
// checked by a scoreboard against a transaction-level fetch model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .pc_out       (pc_out),
        .instruction  (instruction),
        .valid        (valid)
    );

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pco;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model of the fetch stage: next PC, the IF/ID contents, and a 0/1-entry park queue.
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ins;
    logic [31:0] m_pco;
    logic [31:0] park_w[$];
    logic [31:0] park_pc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_v   = 1'b0;
        m_ins = 32'h0;
        m_pco = 32'h0;
        park_w.delete();
        park_pc.delete();
    endtask

    task automatic model_edge(input logic fz, input logic br,
                              input logic [31:0] ba, input logic rdy);
        if (br) begin
            m_pc  = {ba[31:2], 2'b00};
            m_v   = 1'b0;
            m_ins = 32'h0;
            m_pco = 32'h0;
            park_w.delete();
            park_pc.delete();
        end else if (park_w.size() != 0) begin
            if (!fz) begin
                m_ins = park_w.pop_front();
                m_pco = park_pc.pop_front();
                m_v   = 1'b1;
                m_pc  = m_pc + 32'd4;
            end
        end else if (rdy) begin
            if (fz) begin
                park_w.push_back(word_of(m_pc));
                park_pc.push_back(m_pc + 32'd4);
            end else begin
                m_ins = word_of(m_pc);
                m_pco = m_pc + 32'd4;
                m_v   = 1'b1;
                m_pc  = m_pc + 32'd4;
            end
        end else if (!fz) begin
            m_v   = 1'b0;
            m_ins = 32'h0;
        end
    endtask

    // Called at a negedge: drive one cycle, predict the post-edge state, wait a cycle.
    task automatic step(input logic fz, input logic br,
                        input logic [31:0] ba, input logic rdy);
        exp_t e;
        freeze       = fz;
        branch_taken = br;
        branch_addr  = ba;
        imem_ready   = rdy;
        imem_rdata   = rdy ? word_of(imem_addr) : $urandom;
        model_edge(fz, br, ba, rdy);
        e.v    = m_v;
        e.ins  = m_ins;
        e.pco  = m_pco;
        e.req  = (park_w.size() == 0);
        e.addr = m_pc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Called at a negedge: async reset mid-cycle, check, release at the next negedge.
    task automatic do_reset();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pcout", pc_out, 32'h0);
        chk("rst_req", 32'(imem_req), 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("valid", 32'(valid), 32'(e.v));
                chk("instruction", instruction, e.ins);
                chk("pc_out", pc_out, e.pco);
                chk("imem_req", 32'(imem_req), 32'(e.req));
                chk("imem_addr", imem_addr, e.addr);
            end
        end
    end

    initial begin
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Back-to-back fetches: pc_out 4,8,C,10.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("seq_pcout", pc_out, 32'h10);
        chk("seq_instr", instruction, 32'hA000_000C);

        // Memory stalls three cycles at PC=8.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_addr", imem_addr, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stall_pcout", pc_out, 32'hC);

        // Freeze when word@4 returns, release two cycles later.
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("hold_req", 32'(imem_req), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("hold_instr", instruction, 32'hA000_0004);
        chk("hold_pcout", pc_out, 32'h8);
        chk("hold_next", imem_addr, 32'h8);

        // Branch beats freeze and a returning word.
        step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        chk("br_addr", imem_addr, 32'h100);

        // PC wraps past the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pcout", pc_out, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Async reset while parked in HOLD.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_rst_pcout", pc_out, 32'h4);

        for (int i = 0; i < 600; i++) begin
            logic        br;
            logic [31:0] ba;
            br = ($urandom_range(0, 15) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                             : $urandom;
            if ($urandom_range(0, 79) == 0) do_reset();
            step(($urandom_range(0, 3) == 0), br, ba, ($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
